video_timing_monitor: RTL and testbench

Downstream neighbour of the video pattern generator. Sits between the generator's de/hs/vs/rgb outputs and the HDMI transmitter pins.
- Registers the video bus once.
- Measures line and frame geometry on the fly: total and active pixels per line, total and active lines per frame.
- Compares the measurements against the expected 1920x1080 timing.
- Reports lock status, a sticky error flag and a frame counter, so firmware can confirm the DDR3-fed pattern path delivers correct HDMI timing.

---
 rtl/video_timing_pkg.sv | 16 +
 rtl/sync_edge_meter.sv | 38 +++
 rtl/video_timing_monitor.sv | 227 ++++++++++++++++++++++
 tb/tb_video_timing_monitor.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared 1080p timing constants and monitor FSM encoding, also used by the pattern generator.
package video_timing_pkg;

   localparam int VTM_CNT_W   = 12;
   localparam int VTM_H_TOTAL = 2200;
   localparam int VTM_H_ACT   = 1920;
   localparam int VTM_V_TOTAL = 1125;
   localparam int VTM_V_ACT   = 1080;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEASURE = 2'd1,
      ST_LOCKED  = 2'd2
   } vtm_state_e;

endpackage

// File: rtl/sync_edge_meter.sv
// Normalises a sync to active-high, flags its leading edge and measures the
// saturating count of 'inc' events between consecutive leading edges.
module sync_edge_meter #(
   parameter int CNT_W = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             polarity,
   input  logic             sync_in,
   input  logic             inc,
   output logic             lead,
   output logic [CNT_W-1:0] period,
   output logic             sat
);

   logic             act_d, act_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;

   // period includes the edge cycle's own increment, so it is the value to capture
   always_comb begin
      act_d  = polarity ? sync_in : ~sync_in;
      lead   = act_d & ~act_q;
      period = (inc && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
      sat    = &period;
      cnt_d  = lead ? '0 : period;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         act_q <= act_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/video_timing_monitor.sv
// Registers the video bus once and measures line/frame geometry against the
// expected timing, reporting lock, a sticky error and a completed-frame count.
module video_timing_monitor
   import video_timing_pkg::*;
#(
   parameter int CNT_W       = VTM_CNT_W,
   parameter int EXP_H_TOTAL = VTM_H_TOTAL,
   parameter int EXP_H_ACT   = VTM_H_ACT,
   parameter int EXP_V_TOTAL = VTM_V_TOTAL,
   parameter int EXP_V_ACT   = VTM_V_ACT,
   parameter int LOCK_FRAMES = 2
) (
   input  logic             pixel_clk,
   input  logic             pixel_rst_n,
   input  logic             hs_polarity,
   input  logic             vs_polarity,
   input  logic             in_de,
   input  logic             in_hs,
   input  logic             in_vs,
   input  logic [7:0]       in_r,
   input  logic [7:0]       in_g,
   input  logic [7:0]       in_b,
   input  logic             err_clr,
   output logic             out_de,
   output logic             out_hs,
   output logic             out_vs,
   output logic [7:0]       out_r,
   output logic [7:0]       out_g,
   output logic [7:0]       out_b,
   output logic [CNT_W-1:0] meas_h_total,
   output logic [CNT_W-1:0] meas_h_act,
   output logic [CNT_W-1:0] meas_v_total,
   output logic [CNT_W-1:0] meas_v_act,
   output logic             meas_valid,
   output logic             timing_locked,
   output logic             timing_err,
   output logic [15:0]      frame_cnt
);

   localparam int               GW   = $clog2(LOCK_FRAMES + 1);
   localparam logic [CNT_W-1:0] ONES = '1;
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   logic       out_de_q, out_hs_q, out_vs_q;
   logic [7:0] out_r_q, out_g_q, out_b_q;

   always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
      if (!pixel_rst_n) begin
         out_de_q <= 1'b0;
         out_hs_q <= 1'b0;
         out_vs_q <= 1'b0;
         out_r_q  <= '0;
         out_g_q  <= '0;
         out_b_q  <= '0;
      end else begin
         out_de_q <= in_de;
         out_hs_q <= in_hs;
         out_vs_q <= in_vs;
         out_r_q  <= in_r;
         out_g_q  <= in_g;
         out_b_q  <= in_b;
      end
   end

   logic             hs_lead, h_sat, vs_lead, v_sat;
   logic [CNT_W-1:0] h_period, v_period;

   sync_edge_meter #(.CNT_W(CNT_W)) u_line_meter (
      .clk      (pixel_clk),
      .rst_n    (pixel_rst_n),
      .polarity (hs_polarity),
      .sync_in  (in_hs),
      .inc      (1'b1),
      .lead     (hs_lead),
      .period   (h_period),
      .sat      (h_sat)
   );

   // Frame meter counts hs edges, so a coincident hs edge lands in the ending frame
   sync_edge_meter #(.CNT_W(CNT_W)) u_frame_meter (
      .clk      (pixel_clk),
      .rst_n    (pixel_rst_n),
      .polarity (vs_polarity),
      .sync_in  (in_vs),
      .inc      (hs_lead),
      .lead     (vs_lead),
      .period   (v_period),
      .sat      (v_sat)
   );

   logic [CNT_W-1:0] de_cnt_d, de_cnt_q, hact_d, hact_q, hlen_d, hlen_q;
   logic [CNT_W-1:0] act_cnt_d, act_cnt_q, act_sum, h_len_now, h_act_now;
   logic             line_de_d, line_de_q, wvld_d, wvld_q, bad_d, bad_q;
   logic             de_fall, act_inc, width_diff, bad_now, frame_match;

   always_comb begin
      de_fall   = out_de_q & ~in_de;
      de_cnt_d  = de_cnt_q;
      if (de_fall)
         de_cnt_d = '0;
      else if (in_de && (de_cnt_q != ONES))
         de_cnt_d = de_cnt_q + ONE;

      width_diff = de_fall & wvld_q & (de_cnt_q != hact_q);
      h_act_now  = de_fall ? de_cnt_q : hact_q;
      hact_d     = h_act_now;
      h_len_now  = hs_lead ? h_period : hlen_q;
      hlen_d     = h_len_now;

      act_inc   = hs_lead & (line_de_q | in_de);
      act_sum   = (act_inc && (act_cnt_q != ONES)) ? act_cnt_q + ONE : act_cnt_q;
      line_de_d = hs_lead ? 1'b0 : (line_de_q | in_de);

      // any saturated counter poisons the frame so it can never pass as a match
      bad_now = bad_q | width_diff | h_sat | v_sat
              | (de_cnt_q == ONES) | (act_cnt_q == ONES);
      frame_match = !bad_now
                  && (h_len_now == CNT_W'(EXP_H_TOTAL))
                  && (h_act_now == CNT_W'(EXP_H_ACT))
                  && (v_period  == CNT_W'(EXP_V_TOTAL))
                  && (act_sum   == CNT_W'(EXP_V_ACT));

      act_cnt_d = vs_lead ? '0   : act_sum;
      wvld_d    = vs_lead ? 1'b0 : (wvld_q | de_fall);
      bad_d     = vs_lead ? 1'b0 : bad_now;
   end

   always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
      if (!pixel_rst_n) begin
         de_cnt_q  <= '0;
         hact_q    <= '0;
         hlen_q    <= '0;
         act_cnt_q <= '0;
         line_de_q <= 1'b0;
         wvld_q    <= 1'b0;
         bad_q     <= 1'b0;
      end else begin
         de_cnt_q  <= de_cnt_d;
         hact_q    <= hact_d;
         hlen_q    <= hlen_d;
         act_cnt_q <= act_cnt_d;
         line_de_q <= line_de_d;
         wvld_q    <= wvld_d;
         bad_q     <= bad_d;
      end
   end

   vtm_state_e       state_d, state_q;
   logic [GW-1:0]    good_d, good_q;
   logic             good_full, meas_load, mism;
   logic             meas_valid_d, meas_valid_q, err_d, err_q;
   logic [CNT_W-1:0] m_ht_d, m_ht_q, m_ha_d, m_ha_q, m_vt_d, m_vt_q, m_va_d, m_va_q;
   logic [15:0]      frame_cnt_d, frame_cnt_q;

   assign good_full = (good_q >= GW'(LOCK_FRAMES - 1));

   always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
      if (!pixel_rst_n) state_q <= ST_IDLE;
      else              state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:    if (vs_lead) state_d = ST_MEASURE;
         ST_MEASURE: if (vs_lead && frame_match && good_full) state_d = ST_LOCKED;
         ST_LOCKED:  if (vs_lead && !frame_match) state_d = ST_MEASURE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // The first vs edge after IDLE only opens a frame; nothing is reported on it
   always_comb begin
      meas_load    = vs_lead && (state_q != ST_IDLE);
      mism         = meas_load && !frame_match;
      meas_valid_d = meas_load;
      good_d       = good_q;
      if ((state_q == ST_IDLE) || mism)
         good_d = '0;
      else if (meas_load && (state_q == ST_MEASURE))
         good_d = good_q + GW'(1);
      err_d       = mism ? 1'b1 : (err_clr ? 1'b0 : err_q);
      m_ht_d      = meas_load ? h_len_now : m_ht_q;
      m_ha_d      = meas_load ? h_act_now : m_ha_q;
      m_vt_d      = meas_load ? v_period  : m_vt_q;
      m_va_d      = meas_load ? act_sum   : m_va_q;
      frame_cnt_d = frame_cnt_q + 16'(meas_load);
      timing_locked = (state_q == ST_LOCKED);
   end

   always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
      if (!pixel_rst_n) begin
         good_q       <= '0;
         meas_valid_q <= 1'b0;
         err_q        <= 1'b0;
         m_ht_q       <= '0;
         m_ha_q       <= '0;
         m_vt_q       <= '0;
         m_va_q       <= '0;
         frame_cnt_q  <= '0;
      end else begin
         good_q       <= good_d;
         meas_valid_q <= meas_valid_d;
         err_q        <= err_d;
         m_ht_q       <= m_ht_d;
         m_ha_q       <= m_ha_d;
         m_vt_q       <= m_vt_d;
         m_va_q       <= m_va_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

   assign out_de       = out_de_q;
   assign out_hs       = out_hs_q;
   assign out_vs       = out_vs_q;
   assign out_r        = out_r_q;
   assign out_g        = out_g_q;
   assign out_b        = out_b_q;
   assign meas_h_total = m_ht_q;
   assign meas_h_act   = m_ha_q;
   assign meas_v_total = m_vt_q;
   assign meas_v_act   = m_va_q;
   assign meas_valid   = meas_valid_q;
   assign timing_err   = err_q;
   assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_video_timing_monitor.sv
// Scoreboard bench for video_timing_monitor on a scaled-down 20x10 raster
// (12 active clocks, 6 active lines) with 6-bit counters.
module tb_video_timing_monitor;

   localparam int CW = 6;

   logic          pixel_clk = 1'b0;
   logic          pixel_rst_n = 1'b0;
   logic          hs_polarity = 1'b1, vs_polarity = 1'b1;
   logic          in_de = 1'b0, in_hs = 1'b0, in_vs = 1'b0, err_clr = 1'b0;
   logic [7:0]    in_r = '0, in_g = '0, in_b = '0;
   logic          out_de, out_hs, out_vs, meas_valid, timing_locked, timing_err;
   logic [7:0]    out_r, out_g, out_b;
   logic [CW-1:0] meas_h_total, meas_h_act, meas_v_total, meas_v_act;
   logic [15:0]   frame_cnt;

   video_timing_monitor #(
      .CNT_W(CW), .EXP_H_TOTAL(20), .EXP_H_ACT(12),
      .EXP_V_TOTAL(10), .EXP_V_ACT(6), .LOCK_FRAMES(2)
   ) dut (
      .pixel_clk(pixel_clk), .pixel_rst_n(pixel_rst_n),
      .hs_polarity(hs_polarity), .vs_polarity(vs_polarity),
      .in_de(in_de), .in_hs(in_hs), .in_vs(in_vs),
      .in_r(in_r), .in_g(in_g), .in_b(in_b), .err_clr(err_clr),
      .out_de(out_de), .out_hs(out_hs), .out_vs(out_vs),
      .out_r(out_r), .out_g(out_g), .out_b(out_b),
      .meas_h_total(meas_h_total), .meas_h_act(meas_h_act),
      .meas_v_total(meas_v_total), .meas_v_act(meas_v_act),
      .meas_valid(meas_valid), .timing_locked(timing_locked),
      .timing_err(timing_err), .frame_cnt(frame_cnt)
   );

   always #5 pixel_clk = ~pixel_clk;

   typedef struct {
      int ht, ha, vt, va;
      bit lk, er;
      int fc;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   n_tests = 0, n_fail = 0, n_meas = 0;
   int   pix = 0;

   task automatic push_exp(input int ht, input int ha, input int vt, input int va,
                           input bit lk, input bit er, input int fc);
      exp_t x;
      x.ht = ht; x.ha = ha; x.vt = vt; x.va = va; x.lk = lk; x.er = er; x.fc = fc;
      exp_q.push_back(x);
   endtask

   task automatic drive_idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge pixel_clk); #1;
         in_hs = ~hs_polarity; in_vs = ~vs_polarity; in_de = 1'b0; err_clr = 1'b0;
      end
   endtask

   // Lines of ht clocks: hs on clocks 0-1, DE on clocks 4..4+w-1 of lines 2..7,
   // vs on lines 0-1 when vs_en. bad_line gets width 11, clr_line pulses err_clr.
   task automatic send_frame(input int ht, input int nl, input bit vs_en,
                             input int bad_line, input int clr_line);
      bit hs, vs, de;
      int w;
      for (int l = 0; l < nl; l++) begin
         for (int c = 0; c < ht; c++) begin
            @(posedge pixel_clk); #1;
            w  = (l == bad_line) ? 11 : 12;
            hs = (c < 2);
            vs = vs_en && (l < 2);
            de = (l >= 2) && (l < 8) && (c >= 4) && (c < 4 + w);
            in_hs   = hs_polarity ? hs : ~hs;
            in_vs   = vs_polarity ? vs : ~vs;
            in_de   = de;
            in_r    = 8'(pix);
            in_g    = 8'(pix * 3);
            in_b    = 8'(~pix);
            err_clr = (l == clr_line) && (c == 0);
            pix++;
         end
      end
   endtask

   task automatic check_zero(input string name);
      logic [69:0] all_o;
      all_o = {out_de, out_hs, out_vs, out_r, out_g, out_b, meas_h_total, meas_h_act,
               meas_v_total, meas_v_act, meas_valid, timing_locked, timing_err, frame_cnt};
      n_tests++;
      if (all_o != '0) begin
         n_fail++;
         $display("FAIL %s: outputs=%h expected all zero", name, all_o);
      end
   endtask

   // Pass-through: out_* must equal in_* as sampled at the previous edge
   logic [26:0] snap;
   logic        snap_ok = 1'b0;
   always @(posedge pixel_clk) begin
      snap    <= {in_de, in_hs, in_vs, in_r, in_g, in_b};
      snap_ok <= pixel_rst_n;
   end
   always @(negedge pixel_clk) begin
      if (snap_ok && pixel_rst_n) begin
         n_tests++;
         if ({out_de, out_hs, out_vs, out_r, out_g, out_b} != snap) begin
            n_fail++;
            $display("FAIL passthru @%0t: got %h want %h", $time,
                     {out_de, out_hs, out_vs, out_r, out_g, out_b}, snap);
         end
      end
   end

   // Scoreboard monitor: one expectation per meas_valid cycle
   always @(negedge pixel_clk) begin
      if (pixel_rst_n && meas_valid) begin
         n_tests++;
         n_meas++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL meas_unexpected @%0t: meas_valid with empty queue", $time);
         end else begin
            e = exp_q.pop_front();
            if (meas_h_total != CW'(e.ht) || meas_h_act != CW'(e.ha) ||
                meas_v_total != CW'(e.vt) || meas_v_act != CW'(e.va) ||
                timing_locked != e.lk || timing_err != e.er || frame_cnt != 16'(e.fc)) begin
               n_fail++;
               $display("FAIL meas[%0d]: got ht=%0d ha=%0d vt=%0d va=%0d lk=%0b er=%0b fc=%0d, want ht=%0d ha=%0d vt=%0d va=%0d lk=%0b er=%0b fc=%0d",
                        n_meas, meas_h_total, meas_h_act, meas_v_total, meas_v_act,
                        timing_locked, timing_err, frame_cnt,
                        e.ht, e.ha, e.vt, e.va, e.lk, e.er, e.fc);
            end
         end
      end
   end

   initial begin
      in_hs = ~hs_polarity; in_vs = ~vs_polarity;
      repeat (3) @(posedge pixel_clk);
      @(negedge pixel_clk);
      check_zero("reset_state");
      @(posedge pixel_clk); #1;
      pixel_rst_n = 1'b1;
      drive_idle(5);

      // nominal stream, lock after two good frames
      send_frame(20, 10, 1'b1, -1, -1);
      push_exp(20, 12, 10, 6, 1'b0, 1'b0, 1);
      send_frame(20, 10, 1'b1, -1, -1);
      push_exp(20, 12, 10, 6, 1'b1, 1'b0, 2);
      send_frame(20, 10, 1'b1, -1, -1);
      // one long-line frame (h_total 21)
      push_exp(20, 12, 10, 6, 1'b1, 1'b0, 3);
      send_frame(21, 10, 1'b1, -1, -1);
      push_exp(21, 12, 10, 6, 1'b0, 1'b1, 4);
      send_frame(20, 10, 1'b1, -1, -1);
      push_exp(20, 12, 10, 6, 1'b0, 1'b1, 5);
      send_frame(20, 10, 1'b1, -1, -1);
      // relocked; next frame has one 11-wide line, err_clr mid-frame
      push_exp(20, 12, 10, 6, 1'b1, 1'b1, 6);
      send_frame(20, 10, 1'b1, 3, 5);
      n_tests++;
      if (timing_err !== 1'b0) begin
         n_fail++;
         $display("FAIL err_clr: timing_err=%0b want 0", timing_err);
      end
      // err_clr coincides with the mismatching vs edge
      push_exp(20, 12, 10, 6, 1'b0, 1'b1, 7);
      send_frame(20, 10, 1'b1, -1, 0);
      push_exp(20, 12, 10, 6, 1'b0, 1'b1, 8);
      send_frame(20, 10, 1'b1, -1, -1);
      push_exp(20, 12, 10, 6, 1'b1, 1'b1, 9);
      send_frame(20, 10, 1'b1, -1, -1);
      // 70 lines without vs: 80 lines total saturates the line counter at 63
      send_frame(20, 70, 1'b0, -1, -1);
      push_exp(20, 12, 63, 12, 1'b0, 1'b1, 10);
      send_frame(20, 5, 1'b1, -1, -1);

      // reset mid-frame, then inverted hsync
      pixel_rst_n = 1'b0;
      hs_polarity = 1'b0;
      in_hs = ~hs_polarity; in_vs = ~vs_polarity; in_de = 1'b0; err_clr = 1'b0;
      repeat (2) @(posedge pixel_clk);
      @(negedge pixel_clk);
      check_zero("mid_reset");
      @(posedge pixel_clk); #1;
      pixel_rst_n = 1'b1;
      drive_idle(5);

      send_frame(20, 10, 1'b1, -1, -1);
      push_exp(20, 12, 10, 6, 1'b0, 1'b0, 1);
      send_frame(20, 10, 1'b1, -1, -1);
      push_exp(20, 12, 10, 6, 1'b1, 1'b0, 2);
      send_frame(20, 10, 1'b1, -1, -1);
      push_exp(20, 12, 10, 6, 1'b1, 1'b0, 3);
      send_frame(20, 10, 1'b1, -1, -1);
      push_exp(20, 12, 10, 6, 1'b1, 1'b0, 4);
      send_frame(20, 10, 1'b1, -1, -1);

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge pixel_clk);
      @(negedge pixel_clk);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL meas_timeout: %0d expectations left, want 0", exp_q.size());
      end
      n_tests++;
      if (n_meas != 14) begin
         n_fail++;
         $display("FAIL meas_count: saw %0d meas_valid pulses, want 14", n_meas);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
